phys_reg_allocator: RTL and testbench

Physical-register free-list controller for the 2-wide rename stage. It arbitrates the 64-entry physical register pool between the two rename slots each cycle and reclaims registers from the two commit slots. It keeps a speculative free list for rename and an architectural free list, updated only at commit, which is restored into the speculative list on a pipeline flush. It sits between decode/rename and the reorder-buffer commit logic.

---
 rtl/rename_pkg.sv | 36 +++
 rtl/free_pick2.sv | 34 +++
 rtl/phys_reg_allocator.sv | 150 +++++++++++++++
 tb/tb_phys_reg_allocator.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/rename_pkg.sv
// Shared rename-stage definitions: physical/architectural register counts,
// register-index and free-bitmap types, the opcodes the rename stage uses to
// decide whether an instruction needs a destination preg, and a popcount
// helper for the free bitmap.
package rename_pkg;

    localparam int NUM_PREGS = 64;
    localparam int PREG_W    = 6;
    localparam int NUM_AREGS = 32;
    localparam int CNT_W     = PREG_W + 1;

    typedef logic [PREG_W-1:0]    preg_t;
    typedef logic [NUM_PREGS-1:0] free_vec_t;
    typedef logic [CNT_W-1:0]     cnt_t;

    // Opcodes that write a destination register (stores do not, but are
    // listed so the decoder has the full set in one place).
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    // pregs 0..NUM_AREGS-1 hold the reset architectural mapping.
    localparam free_vec_t RESET_FREE = {{(NUM_PREGS-NUM_AREGS){1'b1}}, {NUM_AREGS{1'b0}}};

    // Number of free pregs in a bitmap.
    function automatic cnt_t popcount(input free_vec_t v);
        cnt_t c;
        c = {CNT_W{1'b0}};
        for (int i = 0; i < NUM_PREGS; i++) begin
            c = c + cnt_t'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/free_pick2.sv
// Combinational two-candidate picker: finds the lowest (f0) and
// second-lowest (f1) set bits of a free bitmap.
// Ports: free_vec in; f0/f0_valid, f1/f1_valid out. Indices read as 0
// when the matching valid flag is low.
module free_pick2
    import rename_pkg::*;
(
    input  free_vec_t free_vec,
    output preg_t     f0,
    output logic      f0_valid,
    output preg_t     f1,
    output logic      f1_valid
);

    // Scan from the top down; every set bit becomes the new f0 and pushes
    // the previous f0 into f1, so the loop ends on the two lowest set bits.
    always_comb begin
        f0       = {PREG_W{1'b0}};
        f0_valid = 1'b0;
        f1       = {PREG_W{1'b0}};
        f1_valid = 1'b0;
        for (int i = NUM_PREGS - 1; i >= 0; i--) begin
            if (free_vec[i]) begin
                f1       = f0;
                f1_valid = f0_valid;
                f0       = preg_t'(i);
                f0_valid = 1'b1;
            end else begin
                // bit busy: candidates unchanged
            end
        end
    end

endmodule

// File: rtl/phys_reg_allocator.sv
// Physical-register free-list controller for a 2-wide rename stage.
// Keeps a speculative free bitmap (used for allocation) and an architectural
// free bitmap (updated only by commit) that is copied back on flush.
// Ports:
//   clk, reset                     clock, async active-high reset
//   alloc_req_1/2                  rename slots requesting a destination preg
//   alloc_ready                    all asserted requests are granted this cycle
//   alloc_preg_1/2                 granted (or candidate) pregs per slot
//   commit_valid_1/2               commit slots retiring a register writer
//   commit_new_preg_1/2            preg becoming architectural
//   commit_old_preg_1/2            previous mapping, freed
//   flush                          restore speculative list from architectural
//   free_count                     registered popcount of speculative list
//   double_free_err                registered pulse on freeing a free preg
module phys_reg_allocator
    import rename_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_req_1,
    input  logic              alloc_req_2,
    output logic              alloc_ready,
    output logic [PREG_W-1:0] alloc_preg_1,
    output logic [PREG_W-1:0] alloc_preg_2,
    input  logic              commit_valid_1,
    input  logic [PREG_W-1:0] commit_new_preg_1,
    input  logic [PREG_W-1:0] commit_old_preg_1,
    input  logic              commit_valid_2,
    input  logic [PREG_W-1:0] commit_new_preg_2,
    input  logic [PREG_W-1:0] commit_old_preg_2,
    input  logic              flush,
    output logic [PREG_W:0]   free_count,
    output logic              double_free_err
);

    free_vec_t spec_free_q, spec_free_d;
    free_vec_t arch_free_q, arch_free_d;
    cnt_t      free_count_q, free_count_d;
    logic      double_free_err_q, double_free_err_d;

    preg_t     f0, f1;
    logic      f0_valid, f1_valid;
    preg_t     cand_0, cand_1;
    logic [1:0] num_req;
    preg_t     grant_idx_2;

    logic      cmt_vld [2];
    preg_t     cmt_new [2];
    preg_t     cmt_old [2];

    free_pick2 u_pick (
        .free_vec (spec_free_q),
        .f0       (f0),
        .f0_valid (f0_valid),
        .f1       (f1),
        .f1_valid (f1_valid)
    );

    // Grant side: candidates, readiness and per-slot preg outputs.
    always_comb begin
        cand_0  = f0_valid ? f0 : {PREG_W{1'b0}};
        cand_1  = f1_valid ? f1 : {PREG_W{1'b0}};
        num_req = {1'b0, alloc_req_1} + {1'b0, alloc_req_2};
        // free_count tracks the bitmap exactly, so it alone decides whether
        // both candidates exist; this makes grants all-or-nothing.
        alloc_ready  = !flush && (free_count_q >= cnt_t'(num_req));
        alloc_preg_1 = cand_0;
        if (alloc_req_2 && !alloc_req_1) begin
            alloc_preg_2 = cand_0;
            grant_idx_2  = f0;
        end else begin
            alloc_preg_2 = cand_1;
            grant_idx_2  = f1;
        end
    end

    // Gather the two commit slots so they can be applied in program order.
    always_comb begin
        cmt_vld[0] = commit_valid_1;
        cmt_new[0] = commit_new_preg_1;
        cmt_old[0] = commit_old_preg_1;
        cmt_vld[1] = commit_valid_2;
        cmt_new[1] = commit_new_preg_2;
        cmt_old[1] = commit_old_preg_2;
    end

    // Next-state: commits (slot 1 then slot 2), allocation, flush, count.
    always_comb begin
        spec_free_d       = spec_free_q;
        arch_free_d       = arch_free_q;
        double_free_err_d = 1'b0;

        // The double-free check sees the registered list plus earlier-slot
        // frees, before this cycle's allocation; a preg being granted is
        // still free here, so freeing it is flagged rather than applied.
        for (int s = 0; s < 2; s++) begin
            if (cmt_vld[s]) begin
                arch_free_d[cmt_new[s]] = 1'b0;
                if (cmt_old[s] == {PREG_W{1'b0}}) begin
                    // x0 mapping is never freed
                end else if (spec_free_d[cmt_old[s]]) begin
                    double_free_err_d = 1'b1;
                end else begin
                    arch_free_d[cmt_old[s]] = 1'b1;
                    spec_free_d[cmt_old[s]] = 1'b1;
                end
            end else begin
                // slot idle
            end
        end

        if (alloc_ready && alloc_req_1) begin
            spec_free_d[f0] = 1'b0;
        end else begin
            // slot 1 not allocating
        end
        if (alloc_ready && alloc_req_2) begin
            spec_free_d[grant_idx_2] = 1'b0;
        end else begin
            // slot 2 not allocating
        end

        if (flush) begin
            spec_free_d = arch_free_d;
        end else begin
            // keep speculative state
        end

        free_count_d = popcount(spec_free_d);
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            spec_free_q       <= RESET_FREE;
            arch_free_q       <= RESET_FREE;
            free_count_q      <= cnt_t'(NUM_PREGS - NUM_AREGS);
            double_free_err_q <= 1'b0;
        end else begin
            spec_free_q       <= spec_free_d;
            arch_free_q       <= arch_free_d;
            free_count_q      <= free_count_d;
            double_free_err_q <= double_free_err_d;
        end
    end

    assign free_count      = free_count_q;
    assign double_free_err = double_free_err_q;

endmodule

// File: tb/tb_phys_reg_allocator.sv
// Self-checking bench for phys_reg_allocator: directed scenarios followed by
// randomized traffic, all checked against a set-based reference model.
module tb_phys_reg_allocator;
    import rename_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              alloc_req_1, alloc_req_2, alloc_ready;
    logic [PREG_W-1:0] alloc_preg_1, alloc_preg_2;
    logic              commit_valid_1, commit_valid_2;
    logic [PREG_W-1:0] commit_new_preg_1, commit_old_preg_1;
    logic [PREG_W-1:0] commit_new_preg_2, commit_old_preg_2;
    logic              flush;
    logic [PREG_W:0]   free_count;
    logic              double_free_err;

    int n_vec = 0;
    int n_err = 0;

    // reference model: one flag per preg, 1 = free
    bit m_spec [NUM_PREGS];
    bit m_arch [NUM_PREGS];
    bit m_err;

    phys_reg_allocator dut (
        .clk               (clk),
        .reset             (reset),
        .alloc_req_1       (alloc_req_1),
        .alloc_req_2       (alloc_req_2),
        .alloc_ready       (alloc_ready),
        .alloc_preg_1      (alloc_preg_1),
        .alloc_preg_2      (alloc_preg_2),
        .commit_valid_1    (commit_valid_1),
        .commit_new_preg_1 (commit_new_preg_1),
        .commit_old_preg_1 (commit_old_preg_1),
        .commit_valid_2    (commit_valid_2),
        .commit_new_preg_2 (commit_new_preg_2),
        .commit_old_preg_2 (commit_old_preg_2),
        .flush             (flush),
        .free_count        (free_count),
        .double_free_err   (double_free_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < NUM_PREGS; i++) begin
            m_spec[i] = (i >= NUM_AREGS);
            m_arch[i] = (i >= NUM_AREGS);
        end
        m_err = 1'b0;
    endfunction

    function automatic int m_count();
        int c = 0;
        for (int i = 0; i < NUM_PREGS; i++) c += m_spec[i];
        return c;
    endfunction

    function automatic void m_cands(output int c0, output int c1);
        int q[$];
        for (int i = 0; i < NUM_PREGS; i++) if (m_spec[i]) q.push_back(i);
        c0 = (q.size() > 0) ? q[0] : 0;
        c1 = (q.size() > 1) ? q[1] : 0;
    endfunction

    task automatic idle();
        alloc_req_1 = 1'b0; alloc_req_2 = 1'b0; flush = 1'b0;
        commit_valid_1 = 1'b0; commit_new_preg_1 = 6'd0; commit_old_preg_1 = 6'd0;
        commit_valid_2 = 1'b0; commit_new_preg_2 = 6'd0; commit_old_preg_2 = 6'd0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        m_reset();
    endtask

    // One clock: drive inputs, check outputs against the model, advance model.
    task automatic cycle(input bit r1, input bit r2,
                         input bit cv1, input int cn1, input int co1,
                         input bit cv2, input int cn2, input int co2,
                         input bit fl);
        int  c0, c1, cnt, g1, g2;
        bit  rdy, err;
        bit  vs [2];
        int  ns [2];
        int  os [2];
        @(negedge clk);
        alloc_req_1 = r1; alloc_req_2 = r2; flush = fl;
        commit_valid_1 = cv1; commit_new_preg_1 = PREG_W'(cn1); commit_old_preg_1 = PREG_W'(co1);
        commit_valid_2 = cv2; commit_new_preg_2 = PREG_W'(cn2); commit_old_preg_2 = PREG_W'(co2);
        #1;
        cnt = m_count();
        m_cands(c0, c1);
        rdy = !fl && (cnt >= int'(r1) + int'(r2));
        check("alloc_ready", alloc_ready, rdy);
        check("alloc_preg_1", alloc_preg_1, c0);
        check("alloc_preg_2", alloc_preg_2, (r2 && !r1) ? c0 : c1);
        check("free_count", free_count, cnt);
        check("double_free_err", double_free_err, m_err);

        g1 = c0;
        g2 = r1 ? c1 : c0;
        vs[0] = cv1; ns[0] = cn1; os[0] = co1;
        vs[1] = cv2; ns[1] = cn2; os[1] = co2;
        err = 1'b0;
        for (int s = 0; s < 2; s++) begin
            if (vs[s]) begin
                m_arch[ns[s]] = 1'b0;
                if (os[s] != 0) begin
                    if (m_spec[os[s]]) err = 1'b1;
                    else begin
                        m_arch[os[s]] = 1'b1;
                        m_spec[os[s]] = 1'b1;
                    end
                end
            end
        end
        if (rdy && r1) m_spec[g1] = 1'b0;
        if (rdy && r2) m_spec[g2] = 1'b0;
        if (fl) m_spec = m_arch;
        m_err = err;

        @(posedge clk);
        #1 idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle();
        m_reset();
        #12;
        do_reset();
        #1;
        check("rst_preg_1", alloc_preg_1, 32);
        check("rst_preg_2", alloc_preg_2, 33);
        check("rst_ready", alloc_ready, 1);
        check("rst_count", free_count, 32);
        check("rst_err", double_free_err, 0);

        // dual allocate after reset
        cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);
        check("dual_count", free_count, 30);
        check("dual_next_1", alloc_preg_1, 34);
        check("dual_next_2", alloc_preg_2, 35);

        // slot 2 only
        do_reset();
        cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
        check("r2only_count", free_count, 31);

        // exhaust the pool
        do_reset();
        for (int i = 0; i < 16; i++) cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);
        check("empty_count", free_count, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("empty_hold", free_count, 0);
        cycle(0, 0, 1, 32, 5, 0, 0, 0, 0);
        check("free5_preg", alloc_preg_1, 5);
        check("free5_count", free_count, 1);
        cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);
        check("one_left_dual", free_count, 1);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("one_left_single", free_count, 0);

        // commit then flush restores the architectural list
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 32, 7, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0, 0, 0, 1);
        check("flush_count", free_count, 32);
        check("flush_preg_1", alloc_preg_1, 7);
        check("flush_preg_2", alloc_preg_2, 33);

        // x0 free ignored, double free flagged
        cycle(0, 0, 1, 0, 0, 0, 0, 0, 0);
        check("x0_count", free_count, 32);
        cycle(0, 0, 1, 0, 40, 0, 0, 0, 0);
        check("dfree_pulse", double_free_err, 1);
        check("dfree_count", free_count, 32);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("dfree_clear", double_free_err, 0);

        // asynchronous reset between edges
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        alloc_req_1 = 1'b1; alloc_req_2 = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("arst_preg_1", alloc_preg_1, 32);
        check("arst_preg_2", alloc_preg_2, 33);
        check("arst_count", free_count, 32);
        check("arst_ready", alloc_ready, 1);
        @(posedge clk);
        #1 reset = 1'b0;
        idle();
        m_reset();

        // randomized traffic
        for (int i = 0; i < 800; i++) begin
            cycle($urandom_range(0, 1), $urandom_range(0, 1),
                  ($urandom_range(0, 2) == 0), $urandom_range(0, NUM_PREGS - 1), $urandom_range(0, NUM_PREGS - 1),
                  ($urandom_range(0, 2) == 0), $urandom_range(0, NUM_PREGS - 1), $urandom_range(0, NUM_PREGS - 1),
                  ($urandom_range(0, 15) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
